vga_mode_sched: RTL
===================

VGA_MODE_SCHED -- requirements
Module: vga_mode_sched

Interface
REQ-001 SHALL have parameter N_MODES, default 4: number of display patterns; mode_sel counts 0..N_MODES-1.
REQ-002 SHALL have parameter AUTO_FRAMES, default 120: frames per pattern in auto mode.
REQ-003 SHALL have parameter DB_CYCLES, default 500000: debounce stable time in pixel_clk cycles.
REQ-004 SHALL have port pixel_clk  input  1: the only clock.
REQ-005 SHALL have port sys_rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port video_vs  input  1: vertical sync from the VGA driver, active-low pulse, synchronous to pixel_clk.
REQ-007 SHALL have port key_next_n  input  1: asynchronous pushbutton, active-low; request next pattern.
REQ-008 SHALL have port key_mode_n  input  1: asynchronous pushbutton, active-low; toggle auto/manual.
REQ-009 SHALL have port mode_sel  output  $clog2(N_MODES): pattern select to the display generator.
REQ-010 SHALL have port auto_en  output  1: high in AUTO state.
REQ-011 SHALL have port frame_tick  output  1: one-cycle pulse per frame start.

Function
REQ-012 SHALL define frame start as video_vs sampled low in a cycle after it was sampled high (falling edge; one history register, no synchroniser).
REQ-013 SHALL raise frame_tick for exactly one cycle, registered on the edge where the frame start is detected.
REQ-014 SHALL pass each key through a 2-FF synchroniser and a debouncer: the debounced level changes only after the synchronised input holds a new value for DB_CYCLES consecutive cycles.
REQ-015 SHALL treat a debounced high-to-low transition as one press; release SHALL generate no event.
REQ-016 SHALL latch presses into pend_next / pend_mode flags; repeated presses before the next frame start SHALL coalesce into one.
REQ-017 SHALL apply pending requests only on the frame-start edge, so mode_sel and auto_en change on the same edge frame_tick rises, never mid-frame.
REQ-018 SHALL clear both pending flags on the frame-start edge that applies them; a press landing on that same edge SHALL remain pending for the following frame.
REQ-019 SHALL implement states AUTO and MANUAL; pend_mode at frame start toggles the state.
REQ-020 SHALL, in AUTO, count frame starts in frame_cnt; at a frame start with frame_cnt = AUTO_FRAMES-1, increment mode_sel and clear frame_cnt.
REQ-021 SHALL, on pend_next at frame start, increment mode_sel in either state and clear frame_cnt.
REQ-022 SHALL increment mode_sel by exactly one when auto-advance and pend_next coincide.
REQ-023 SHALL wrap mode_sel from N_MODES-1 to 0.
REQ-024 SHALL, on entering AUTO, clear frame_cnt; frame_cnt SHALL hold in MANUAL.
REQ-025 SHALL, when pend_mode and pend_next coincide, toggle the state and advance mode_sel on the same edge.

Reset
REQ-026 SHALL reset asynchronously: mode_sel=0, auto_en=1 (AUTO), frame_tick=0, frame_cnt=0, pending flags=0, vs history=1, synchronisers and debounced levels=1 (released).
REQ-027 SHALL discard any press or partial debounce count in progress when reset asserts mid-operation; no event after release of reset without a fresh press.

Structure
REQ-028 SHALL place state encoding (AUTO, MANUAL) and default N_MODES in shared package vga_pkg.
REQ-029 SHALL use one sub-module, key_debounce (synchroniser + debounce + press pulse), instantiated twice.

Verification (DB_CYCLES=4, AUTO_FRAMES=3, N_MODES=4, short frames)
REQ-030 Reset released, 7 frames, no keys -> frame_tick once per frame; mode_sel 0 until 3rd frame start, 1 at 3rd, 2 at 6th; auto_en=1.
REQ-031 key_mode_n low 10 cycles mid-frame -> auto_en falls exactly at next frame start; mode_sel then holds over 6 frames.
REQ-032 MANUAL, mode_sel=3, key_next_n pressed 3 times within one frame -> mode_sel=0 at next frame start (single wrapping advance), unchanged mid-frame.
REQ-033 key_next_n glitch low 3 cycles -> no advance; held 4+ cycles -> advance at next frame start.
REQ-034 AUTO, frame_cnt=2 with pend_next set -> mode_sel advances by 1 only, frame_cnt=0.
REQ-035 sys_rst_n asserted mid-frame with pend_next set and mode_sel=2 -> immediately mode_sel=0, auto_en=1, frame_tick=0; no advance at following frame start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    // Scheduler states: AUTO cycles patterns on a frame count, MANUAL holds.
    typedef enum logic {
        ST_AUTO   = 1'b0,
        ST_MANUAL = 1'b1
    } sched_state_t;

    // Default number of display patterns.
    localparam int N_MODES_DEF = 4;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, level debouncer, press pulse.
// Latency: press fires 2 sync cycles + DB_CYCLES stable cycles + 1 after key falls.
// Backpressure: none; press is a single-cycle pulse with no handshake.
//
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset (key treated as released)
//   key_n  - raw asynchronous key, active-low
//   press  - one-cycle pulse per debounced press (release makes no pulse)
module key_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          db_lvl;
    logic [CW-1:0] db_cnt;
    logic          db_done;

    // Last cycle of a full stable run of a value different from db_lvl.
    assign db_done = (sync2 != db_lvl) && (db_cnt == CW'(DB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            db_lvl <= 1'b1;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= db_done && db_lvl;   // only the high-to-low move is a press
            if (sync2 == db_lvl) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_lvl <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_mode_sched.sv
// Selects the VGA test pattern; auto-advances every AUTO_FRAMES frames or on key.
// Latency: all changes land on the frame-start edge (1 cycle after vs falls).
// Backpressure: none; key presses coalesce into one pending request per frame.
//
// Ports:
//   pixel_clk  - only clock
//   sys_rst_n  - asynchronous active-low reset
//   video_vs   - active-low vertical sync, synchronous to pixel_clk
//   key_next_n - async pushbutton, advance pattern
//   key_mode_n - async pushbutton, toggle auto/manual
//   mode_sel   - pattern select
//   auto_en    - high while in AUTO
//   frame_tick - one-cycle pulse at each frame start
module vga_mode_sched
    import vga_pkg::*;
#(
    parameter int N_MODES     = N_MODES_DEF,
    parameter int AUTO_FRAMES = 120,
    parameter int DB_CYCLES   = 500000,
    localparam int MW = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic          pixel_clk,
    input  logic          sys_rst_n,
    input  logic          video_vs,
    input  logic          key_next_n,
    input  logic          key_mode_n,
    output logic [MW-1:0] mode_sel,
    output logic          auto_en,
    output logic          frame_tick
);

    localparam int FW = $clog2(AUTO_FRAMES + 1);

    sched_state_t  state;
    logic [FW-1:0] frame_cnt;
    logic          vs_q;
    logic          frame_start;
    logic          press_next;
    logic          press_mode;
    logic          pend_next;
    logic          pend_mode;
    logic          auto_adv;
    logic          advance;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_next (
        .clk   (pixel_clk),
        .rst_n (sys_rst_n),
        .key_n (key_next_n),
        .press (press_next)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
        .clk   (pixel_clk),
        .rst_n (sys_rst_n),
        .key_n (key_mode_n),
        .press (press_mode)
    );

    assign frame_start = vs_q && !video_vs;
    assign auto_adv    = (state == ST_AUTO) && (frame_cnt == FW'(AUTO_FRAMES - 1));
    // Auto-advance and a key request on the same frame still move by one.
    assign advance     = pend_next || auto_adv;
    assign auto_en     = (state == ST_AUTO);

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_AUTO;
            mode_sel   <= '0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            vs_q       <= 1'b1;
            pend_next  <= 1'b0;
            pend_mode  <= 1'b0;
        end else begin
            vs_q       <= video_vs;
            frame_tick <= frame_start;
            if (frame_start) begin
                // Requests are consumed here; a press arriving on this very
                // edge becomes the pending request for the next frame.
                pend_next <= press_next;
                pend_mode <= press_mode;

                if (pend_mode) begin
                    state <= (state == ST_AUTO) ? ST_MANUAL : ST_AUTO;
                    if (state == ST_MANUAL) begin
                        frame_cnt <= '0;
                    end
                end else if (advance) begin
                    frame_cnt <= '0;
                end else if (state == ST_AUTO) begin
                    frame_cnt <= frame_cnt + FW'(1);
                end

                if (advance) begin
                    mode_sel <= (mode_sel == MW'(N_MODES - 1)) ? '0 : mode_sel + MW'(1);
                end
            end else begin
                pend_next <= pend_next || press_next;
                pend_mode <= pend_mode || press_mode;
            end
        end
    end

endmodule
